// File: rtl/led_pkg.sv
// Shared mode encoding for the LED mode sequencer and its prescaler.
package led_pkg;

    typedef enum logic [1:0] {
        LED_MODE_OFF   = 2'd0,
        LED_MODE_SOLID = 2'd1,
        LED_MODE_BLINK = 2'd2,
        LED_MODE_CHASE = 2'd3
    } led_mode_t;

    // Plain constants for the FSM so the state register stays a bare vector.
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_SOLID = 2'd1;
    localparam logic [1:0] ST_BLINK = 2'd2;
    localparam logic [1:0] ST_CHASE = 2'd3;

    function automatic logic [1:0] mode_advance(input logic [1:0] m);
        return m + 2'd1;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides the tick strobe by SLOW_DIV and toggles the BLINK phase on each wrap.
module led_tick_prescaler
    import led_pkg::*;
#(
    parameter int SLOW_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic phase
);

    localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SLOW_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Clear beats enable so a tick in the entry cycle is dropped.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (enable && tick) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Four-mode LED sequencer: OFF / SOLID / BLINK / CHASE driven by button pulses and a tick.
module led_mode_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int SLOW_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                btn_adv,
    input  logic                btn_off,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                mode_chg
);

    logic [1:0]          state_q, state_d;
    logic [NUM_LEDS-1:0] chase_q, chase_d;
    logic                chg_q;
    logic                change;
    logic                blink_phase;

    // btn_off has priority; in OFF it is a no-op and not a transition.
    always_comb begin
        state_d = state_q;
        change  = 1'b0;
        if (btn_off) begin
            state_d = ST_OFF;
            change  = (state_q != ST_OFF);
        end else if (btn_adv) begin
            state_d = mode_advance(state_q);
            change  = 1'b1;
        end
    end

    always_comb begin
        chase_d = chase_q;
        if (change) begin
            chase_d = {{(NUM_LEDS-1){1'b0}}, 1'b1};
        end else if ((state_q == ST_CHASE) && tick) begin
            chase_d = {chase_q[NUM_LEDS-2:0], chase_q[NUM_LEDS-1]};
        end
    end

    led_tick_prescaler #(
        .SLOW_DIV (SLOW_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (change),
        .enable ((state_q == ST_BLINK) && !change),
        .tick   (tick),
        .phase  (blink_phase)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            chase_q <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chase_q <= chase_d;
            chg_q   <= change;
        end
    end

    // LED drive is a pure decode of flops: no input-to-output path.
    always_comb begin
        led = '0;
        case (state_q)
            ST_SOLID: led = '1;
            ST_BLINK: led = {NUM_LEDS{blink_phase}};
            ST_CHASE: led = chase_q;
            default:  led = '0;
        endcase
    end

    assign mode     = state_q;
    assign mode_chg = chg_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Table-driven scoreboard bench for led_mode_sequencer (main DUT SLOW_DIV=4, side DUT SLOW_DIV=1).
module tb_led_mode_sequencer;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tick = 1'b0;
    logic          btn_adv = 1'b0;
    logic          btn_off = 1'b0;
    logic [NL-1:0] led;
    logic [1:0]    mode;
    logic          mode_chg;
    logic [1:0]    led1;
    logic [1:0]    mode1;
    logic          chg1;

    always #5 clk = ~clk;

    led_mode_sequencer #(.NUM_LEDS(NL), .SLOW_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_adv(btn_adv), .btn_off(btn_off),
        .led(led), .mode(mode), .mode_chg(mode_chg)
    );

    led_mode_sequencer #(.NUM_LEDS(2), .SLOW_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_adv(btn_adv), .btn_off(btn_off),
        .led(led1), .mode(mode1), .mode_chg(chg1)
    );

    typedef struct {
        logic       adv;
        logic       off;
        logic       tk;
        logic [1:0] m;
        logic [3:0] l;
        logic       c;
    } vec_t;

    typedef struct {
        logic [1:0] m;
        logic [3:0] l;
        logic       c;
        logic       chk1;
        logic [1:0] l1;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stepno = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] m, input logic [3:0] l, input logic c);
        exp_t e;
        e.m = m; e.l = l; e.c = c; e.chk1 = 1'b0; e.l1 = 2'b00;
        return e;
    endfunction

    task automatic step(input logic adv, input logic off, input logic tk, input exp_t e);
        exp_t got;
        @(negedge clk);
        btn_adv = adv; btn_off = off; tick = tk;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        btn_adv = 1'b0; btn_off = 1'b0; tick = 1'b0;
        stepno++;
        if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty step %0d: got 0 entries expected 1", stepno);
        end else begin
            got = sbq.pop_front();
            cmp($sformatf("mode step%0d", stepno), 32'(mode), 32'(got.m));
            cmp($sformatf("led step%0d", stepno), 32'(led), 32'(got.l));
            cmp($sformatf("mode_chg step%0d", stepno), 32'(mode_chg), 32'(got.c));
            if (got.chk1) cmp($sformatf("led_div1 step%0d", stepno), 32'(led1), 32'(got.l1));
        end
    endtask

    // Asynchronous assert mid-cycle; outputs must clear without waiting for an edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp({name, "_mode"}, 32'(mode), 32'd0);
        cmp({name, "_led"}, 32'(led), 32'd0);
        cmp({name, "_chg"}, 32'(mode_chg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        // adv, off, tick, mode, led, chg
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 4'hF, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd3, 4'h1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 4'h2, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 4'h4, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 4'h8, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 4'h1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 4'h2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd2, 4'hF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd3, 4'h1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'hF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 4'h0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1});

        repeat (2) @(posedge clk);
        #1;
        cmp("reset_mode", 32'(mode), 32'd0);
        cmp("reset_led", 32'(led), 32'd0);
        cmp("reset_chg", 32'(mode_chg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i].adv, tbl[i].off, tbl[i].tk, mk(tbl[i].m, tbl[i].l, tbl[i].c));

        // Reset mid-BLINK after 3 ticks; counter must restart from zero.
        step(1'b1, 1'b0, 1'b0, mk(2'd1, 4'hF, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(2'd2, 4'hF, 1'b1));
        repeat (3) step(1'b0, 1'b0, 1'b1, mk(2'd2, 4'hF, 1'b0));
        async_reset("rst_blink");
        step(1'b1, 1'b0, 1'b0, mk(2'd1, 4'hF, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(2'd2, 4'hF, 1'b1));
        repeat (3) step(1'b0, 1'b0, 1'b1, mk(2'd2, 4'hF, 1'b0));
        step(1'b0, 1'b0, 1'b1, mk(2'd2, 4'h0, 1'b0));

        // Reset mid-CHASE, then re-enter CHASE: pattern restarts at bit 0.
        step(1'b1, 1'b0, 1'b0, mk(2'd3, 4'h1, 1'b1));
        step(1'b0, 1'b0, 1'b1, mk(2'd3, 4'h2, 1'b0));
        step(1'b0, 1'b0, 1'b1, mk(2'd3, 4'h4, 1'b0));
        async_reset("rst_chase");
        step(1'b1, 1'b0, 1'b0, mk(2'd1, 4'hF, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(2'd2, 4'hF, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(2'd3, 4'h1, 1'b1));
        step(1'b0, 1'b0, 1'b1, mk(2'd3, 4'h2, 1'b0));

        // Reset while mode_chg is high clears it at once.
        step(1'b0, 1'b1, 1'b0, mk(2'd0, 4'h0, 1'b1));
        async_reset("rst_chg");

        // SLOW_DIV=1 side DUT: BLINK phase toggles on every tick.
        step(1'b1, 1'b0, 1'b0, mk(2'd1, 4'hF, 1'b1));
        e = mk(2'd2, 4'hF, 1'b1); e.chk1 = 1'b1; e.l1 = 2'b11;
        step(1'b1, 1'b0, 1'b0, e);
        e = mk(2'd2, 4'hF, 1'b0); e.chk1 = 1'b1; e.l1 = 2'b00;
        step(1'b0, 1'b0, 1'b1, e);
        e.l1 = 2'b11;
        step(1'b0, 1'b0, 1'b1, e);
        e.l1 = 2'b00;
        step(1'b0, 1'b0, 1'b1, e);
        e.l = 4'h0; e.l1 = 2'b11;
        step(1'b0, 1'b0, 1'b1, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 4, number of driven LEDs; legal range 2..16.
REQ-002 Parameter SLOW_DIV, default 4, BLINK half-period in ticks; legal range 1..256.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tick  input  1  one-cycle timebase strobe from the clock divider, synchronous to clk.
REQ-006 btn_adv  input  1  one-cycle debounced pulse; advances to the next mode.
REQ-007 btn_off  input  1  one-cycle debounced pulse; forces mode OFF.
REQ-008 led  output  NUM_LEDS  registered LED drive, 1 = lit.
REQ-009 mode  output  2  registered current mode encoding.
REQ-010 mode_chg  output  1  registered one-cycle pulse, high in the cycle after any mode change.

Function
REQ-011 The FSM SHALL have four states: OFF=0, SOLID=1, BLINK=2, CHASE=3; mode SHALL equal the state.
REQ-012 btn_adv SHALL move OFF->SOLID->BLINK->CHASE->OFF, wrapping from 3 to 0.
REQ-013 btn_off SHALL move any state to OFF; btn_off wins when btn_off and btn_adv are both high.
REQ-014 btn_off while already in OFF SHALL NOT assert mode_chg.
REQ-015 In OFF, led SHALL be all zeros.
REQ-016 In SOLID, led SHALL be all ones.
REQ-017 In BLINK, all LEDs SHALL show a common phase bit.
REQ-018 The BLINK phase bit SHALL toggle on every SLOW_DIV-th tick.
REQ-019 In CHASE, led SHALL be one-hot and rotate one position toward the MSB on each tick, wrapping from bit NUM_LEDS-1 to bit 0.
REQ-020 On entry to any state, the tick counter SHALL clear to 0, BLINK phase SHALL be 1 (lit), and the CHASE pattern SHALL be bit 0 only.
REQ-021 The tick counter SHALL be clog2(SLOW_DIV) bits wide, minimum 1.
REQ-022 The tick counter SHALL count only in BLINK.
REQ-023 On a tick with the counter at SLOW_DIV-1, the counter SHALL wrap to 0 and the phase SHALL toggle.
REQ-024 With SLOW_DIV=1, the BLINK phase SHALL toggle on every tick.
REQ-025 The counter SHALL NOT overflow past SLOW_DIV-1.
REQ-026 Latency: led and mode SHALL reflect a button or tick event exactly one clk cycle after the event cycle.
REQ-027 A tick coincident with a mode change SHALL be discarded; the new state starts from its REQ-020 entry values.
REQ-028 Ticks in OFF or SOLID SHALL have no effect.
REQ-029 Consecutive-cycle button pulses SHALL each be honoured; there is no internal lockout.
REQ-030 mode_chg SHALL be high for exactly one cycle per accepted transition.

Reset
REQ-031 Asserting rst_n low SHALL immediately force: mode=OFF, led=0, mode_chg=0, tick counter=0, BLINK phase=1, CHASE pattern=bit 0.
REQ-032 Reset asserted mid-BLINK or mid-CHASE SHALL discard all progress; no state survives reset.
REQ-033 The first tick or button accepted SHALL be in the first rising clk edge after rst_n deasserts.

Structure
REQ-034 The shared package led_pkg SHALL hold the mode enum typedef (led_mode_t) and the mode encoding constants.
REQ-035 The tick counter and phase toggle SHALL live in one sub-module, led_tick_prescaler, with inputs clear, enable, tick and output phase.
REQ-036 The top level SHALL contain the FSM, the CHASE rotate register and the output registers only.

Verification
REQ-037 Reset, then btn_adv x1 -> next cycle mode=1, led=4'b1111, mode_chg=1 for one cycle.
REQ-038 Enter BLINK with SLOW_DIV=4, then 8 ticks -> led 1111 on entry, 0000 after tick 4, 1111 after tick 8.
REQ-039 Enter CHASE, then 5 ticks -> led sequence 0001, 0010, 0100, 1000, 0001, 0010.
REQ-040 btn_adv and btn_off high together in CHASE with a tick in the same cycle -> mode=0, led=0000, mode_chg=1, tick ignored.
REQ-041 rst_n low for 1 cycle mid-BLINK after 3 ticks, then re-enter BLINK -> counter restarts; first toggle after 4 ticks, not 1.
REQ-042 btn_off in OFF, then btn_adv x4 on consecutive cycles -> no mode_chg for the btn_off; modes 1, 2, 3, 0 with four mode_chg pulses.
